// File: rtl/debruijn_seq.sv
// Binary de Bruijn B(2,N) generator stepped by synchronised edges of a slow
// divider clock (run mode) or a pushbutton (idle mode).
module debruijn_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         slow_clk,
  input  logic         run,
  input  logic         step,
  input  logic         clear,
  output logic         bit_out,
  output logic [N-1:0] window,
  output logic [N-1:0] pos,
  output logic         wrap,
  output logic         adv
);

  typedef enum logic {IDLE, RUN} state_t;

  if (N < 3 || N > 8) begin : g_bad_order
    $error("debruijn_seq: N must be in 3..8");
  end

  // Primitive-polynomial taps, indexed by window bit.
  function automatic logic [7:0] tap_mask(input int n);
    case (n)
      3:       tap_mask = 8'b0000_0110;
      4:       tap_mask = 8'b0000_1100;
      5:       tap_mask = 8'b0001_0100;
      6:       tap_mask = 8'b0011_0000;
      7:       tap_mask = 8'b0110_0000;
      8:       tap_mask = 8'b1011_1000;
      default: tap_mask = 8'b0000_0000;
    endcase
  endfunction

  localparam logic [7:0] TAPS = tap_mask(N);

  // Bit 0 = s1, bit 1 = s2, bit 2 = s3 (edge register).
  logic [2:0] slow_sync, step_sync;
  logic       slow_arm, step_arm;
  logic [1:0] fill;
  logic       filled;
  logic       slow_edge, step_edge;

  // fill marks when s2 holds a real post-reset sample, so a level that was
  // already high at release cannot arm the path through the reset zeros.
  assign filled = fill[1];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slow_sync <= '0;
      step_sync <= '0;
      fill      <= '0;
      slow_arm  <= 1'b0;
      step_arm  <= 1'b0;
    end else begin
      slow_sync <= {slow_sync[1:0], slow_clk};
      step_sync <= {step_sync[1:0], step};
      fill      <= {fill[0], 1'b1};
      if (filled && !slow_sync[1]) slow_arm <= 1'b1;
      if (filled && !step_sync[1]) step_arm <= 1'b1;
    end
  end

  assign slow_edge = slow_arm & slow_sync[1] & ~slow_sync[2];
  assign step_edge = step_arm & step_sync[1] & ~step_sync[2];

  state_t state, state_next;
  logic   adv_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    adv_req    = 1'b0;
    case (state)
      IDLE: begin
        adv_req = step_edge;
        if (run) state_next = RUN;
      end
      RUN: begin
        adv_req = slow_edge;
        if (!run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  logic [7:0] w_ext;
  logic       fb, zero_run, new_bit;

  assign w_ext    = 8'(window);
  assign fb       = ^(w_ext & TAPS);
  // Inserting the all-zero window turns the 2^N-1 LFSR cycle into 2^N.
  assign zero_run = (window[N-2:0] == '0);
  assign new_bit  = fb ^ zero_run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window <= '0;
      pos    <= '0;
      adv    <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      adv  <= 1'b0;
      wrap <= 1'b0;
      if (clear) begin
        window <= '0;
        pos    <= '0;
      end else if (adv_req) begin
        window <= {window[N-2:0], new_bit};
        pos    <= pos + 1'b1;
        adv    <= 1'b1;
        wrap   <= (pos == '1);
      end
    end
  end

  assign bit_out = window[0];

endmodule

// File: tb/tb_debruijn_seq.sv
// Directed bench for debruijn_seq: N=4 sequence, arming, step mode, clear,
// async reset, and full-period uniqueness for N=3 and N=8.
module tb_debruijn_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic slow_clk = 1'b0;
  logic run = 1'b0;
  logic step = 1'b0;
  logic clear = 1'b0;

  logic       b4, wr4, a4;
  logic [3:0] w4, p4;
  logic       b3, wr3, a3;
  logic [2:0] w3, p3;
  logic       b8, wr8, a8;
  logic [7:0] w8, p8;

  always #5 clk = ~clk;

  debruijn_seq #(.N(4)) u4 (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .run(run), .step(step), .clear(clear),
    .bit_out(b4), .window(w4), .pos(p4), .wrap(wr4), .adv(a4)
  );
  debruijn_seq #(.N(3)) u3 (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .run(run), .step(step), .clear(clear),
    .bit_out(b3), .window(w3), .pos(p3), .wrap(wr3), .adv(a3)
  );
  debruijn_seq #(.N(8)) u8 (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .run(run), .step(step), .clear(clear),
    .bit_out(b8), .window(w8), .pos(p8), .wrap(wr8), .adv(a8)
  );

  int checks = 0;
  int errors = 0;

  // Pulse counters and window scoreboards, sampled on the falling edge.
  bit         mon_clr = 1'b0;
  int         adv4, wrap4, adv3, wrap3, dup3, new3, adv8, wrap8, dup8, new8;
  logic [3:0] wrap_win4, wrap_pos4;
  bit         seen3 [8];
  bit         seen8 [256];

  always @(negedge clk) begin
    if (mon_clr) begin
      adv4 <= 0; wrap4 <= 0; wrap_win4 <= 4'hx; wrap_pos4 <= 4'hx;
      adv3 <= 0; wrap3 <= 0; dup3 <= 0; new3 <= 0;
      adv8 <= 0; wrap8 <= 0; dup8 <= 0; new8 <= 0;
      foreach (seen3[i]) seen3[i] <= 1'b0;
      foreach (seen8[i]) seen8[i] <= 1'b0;
      seen3[0] <= 1'b1;
      seen8[0] <= 1'b1;
    end else begin
      if (a4) adv4 <= adv4 + 1;
      if (wr4) begin
        wrap4     <= wrap4 + 1;
        wrap_win4 <= w4;
        wrap_pos4 <= p4;
      end
      if (a3) begin
        if (adv3 < 7) begin
          if (seen3[w3]) dup3 <= dup3 + 1;
          else           new3 <= new3 + 1;
          seen3[w3] <= 1'b1;
        end
        adv3 <= adv3 + 1;
      end
      if (wr3) wrap3 <= wrap3 + 1;
      if (a8) begin
        if (adv8 < 255) begin
          if (seen8[w8]) dup8 <= dup8 + 1;
          else           new8 <= new8 + 1;
          seen8[w8] <= 1'b1;
        end
        adv8 <= adv8 + 1;
      end
      if (wr8) wrap8 <= wrap8 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  // One input pulse: 4 clk high, 4 clk low.
  task automatic pulse(input bit do_slow, input bit do_step);
    if (do_slow) slow_clk = 1'b1;
    if (do_step) step = 1'b1;
    repeat (4) @(negedge clk);
    slow_clk = 1'b0;
    step = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  logic [3:0] seq4 [16] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD,
                            4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  logic [3:0] exp_w;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_window", w4, 0);
    check("rst_pos", p4, 0);
    check("rst_bit", b4, 0);
    check("rst_wrap", wr4, 0);
    check("rst_adv", a4, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Free-run through a full N=4 period and one more edge
    run = 1'b1;
    @(negedge clk);
    clr_mon();
    for (int k = 1; k <= 16; k++) begin
      pulse(1'b1, 1'b0);
      exp_w = seq4[k % 16];
      check("run_window", w4, exp_w);
      check("run_bit", b4, exp_w[0]);
      check("run_pos", p4, k % 16);
    end
    check("run_adv_count", adv4, 16);
    check("run_wrap_count", wrap4, 1);
    check("run_wrap_window", wrap_win4, 0);
    check("run_wrap_pos", wrap_pos4, 0);
    pulse(1'b1, 1'b0);
    check("run_edge17_window", w4, 4'h1);
    check("run_edge17_pos", p4, 1);
    check("run_edge17_wrap_count", wrap4, 1);

    // slow_clk high through reset release must not advance until re-armed
    rst = 1'b0;
    slow_clk = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    clr_mon();
    repeat (6) @(negedge clk);
    check("arm_hold_window", w4, 0);
    check("arm_hold_pos", p4, 0);
    check("arm_hold_adv_count", adv4, 0);
    slow_clk = 1'b0;
    repeat (4) @(negedge clk);
    slow_clk = 1'b1;
    @(negedge clk);
    check("arm_lat_edge1", w4, 0);
    @(negedge clk);
    check("arm_lat_edge2", w4, 0);
    @(negedge clk);
    check("arm_lat_edge3", w4, 4'h1);
    check("arm_lat_adv", a4, 1);
    slow_clk = 1'b0;
    repeat (4) @(negedge clk);
    check("arm_adv_count", adv4, 1);

    // Plain clear, then step mode with concurrent slow_clk edges
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_window", w4, 0);
    check("clear_pos", p4, 0);
    run = 1'b0;
    @(negedge clk);
    clr_mon();
    repeat (3) pulse(1'b1, 1'b1);
    check("step_window", w4, 4'b0100);
    check("step_pos", p4, 3);
    check("step_adv_count", adv4, 3);
    repeat (2) pulse(1'b1, 1'b0);
    check("idle_slow_ignored", w4, 4'b0100);
    check("idle_slow_ignored_pos", p4, 3);
    run = 1'b1;
    @(negedge clk);
    pulse(1'b0, 1'b1);
    check("run_step_ignored", w4, 4'b0100);
    run = 1'b0;
    @(negedge clk);

    // clear coincident with an advance at window 1101
    repeat (4) pulse(1'b0, 1'b1);
    check("pre_clear_window", w4, 4'hD);
    check("pre_clear_pos", p4, 7);
    clr_mon();
    step = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_adv_window", w4, 0);
    check("clr_adv_pos", p4, 0);
    check("clr_adv_adv", a4, 0);
    check("clr_adv_wrap", wr4, 0);
    repeat (2) @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    check("clr_adv_count", adv4, 0);
    pulse(1'b0, 1'b1);
    check("clr_state_kept", w4, 4'h1);

    // Asynchronous reset between edges with an advance pending
    run = 1'b1;
    @(negedge clk);
    repeat (3) pulse(1'b1, 1'b0);
    check("pre_rst_window", w4, 4'h9);
    check("pre_rst_pos", p4, 4);
    slow_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_window", w4, 0);
    check("async_rst_pos", p4, 0);
    check("async_rst_bit", b4, 0);
    check("async_rst_wrap", wr4, 0);
    check("async_rst_adv", a4, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    clr_mon();
    repeat (6) @(negedge clk);
    check("post_rst_unarmed", w4, 0);
    check("post_rst_adv_count", adv4, 0);
    slow_clk = 1'b0;
    repeat (4) @(negedge clk);
    pulse(1'b1, 1'b0);
    check("post_rst_rearmed", w4, 4'h1);
    check("post_rst_pos", p4, 1);

    // Full periods: N=8 once, N=3 thirty-two times, N=4 sixteen times
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    clr_mon();
    repeat (256) pulse(1'b1, 1'b0);
    check("n8_dup", dup8, 0);
    check("n8_new", new8, 255);
    check("n8_window_end", w8, 0);
    check("n8_pos_end", p8, 0);
    check("n8_wrap_count", wrap8, 1);
    check("n8_adv_count", adv8, 256);
    check("n3_dup", dup3, 0);
    check("n3_new", new3, 7);
    check("n3_window_end", w3, 0);
    check("n3_wrap_count", wrap3, 32);
    check("n4_wrap_count", wrap4, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
